div_issue_ctrl: RTL and testbench

- Execute-stage front end for the iterative radix-2 divider: accepts DIV/DIVU/REM/REMU and their W forms from the EXU dispatch, and resolves the RISC-V special cases (divide-by-zero, signed overflow) locally in one cycle.
- Otherwise it launches the divider, holds its operands stable for the whole computation, and captures the divider's one-cycle result pulse.
- The selected, sign-extended result goes downstream to writeback over a valid/ready handshake.

---
 rtl/div_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage front end for the iterative radix-2 divider.
// It handles divide-by-zero and signed overflow locally, launches the divider
// for every other case, and hands the final result to writeback over
// a valid/ready handshake.
module div_issue_ctrl #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            div_valid,
    output logic            div_flush,
    output logic            div_word,
    output logic [1:0]      div_signed,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic            word_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] data_q;

    logic            in_signed;
    logic [XLEN-1:0] ext_a;
    logic [XLEN-1:0] ext_b;
    logic [XLEN-1:0] min_neg;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_data;
    logic            accept;

    // W results are always sign-extended from bit 31, unsigned forms included
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    assign in_signed = !in_op[0];
    assign accept    = (state == IDLE) && in_valid && !flush;

    // Operand extension, special-case detection and special-case result
    always_comb begin
        ext_a = in_src1;
        ext_b = in_src2;
        if (in_word) begin
            ext_a = in_signed ? {{(XLEN-32){in_src1[31]}}, in_src1[31:0]}
                              : {{(XLEN-32){1'b0}}, in_src1[31:0]};
            ext_b = in_signed ? {{(XLEN-32){in_src2[31]}}, in_src2[31:0]}
                              : {{(XLEN-32){1'b0}}, in_src2[31:0]};
        end
        // Most-negative value of the operating width, already sign-extended
        min_neg  = in_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (ext_b == '0);
        ovf      = in_signed && (ext_b == '1) && (ext_a == min_neg);
        special  = div_zero || ovf;
        // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
        if (in_op[1])
            spec_data = fmt(div_zero ? ext_a : '0, in_word);
        else
            spec_data = fmt(div_zero ? '1 : ext_a, in_word);
    end

    // Control FSM with operand, tag and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= '0;
            word_q <= 1'b0;
            rd_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= in_op;
                        word_q <= in_word;
                        rd_q   <= in_rd;
                        a_q    <= ext_a;
                        b_q    <= ext_b;
                        if (special) begin
                            data_q <= spec_data;
                            state  <= DONE;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush)          state <= IDLE;
                    else if (div_ready) state <= WAIT;
                end
                WAIT: begin
                    // A result pulse coinciding with flush is dropped
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_out_valid) begin
                        data_q <= fmt(op_q[1] ? div_remainder : div_quotient, word_q);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign div_valid    = (state == ISSUE) && !flush;
    assign div_flush    = (state == WAIT) && flush;
    assign div_word     = word_q;
    assign div_signed   = {2{!op_q[0]}};
    assign div_dividend = a_q;
    assign div_divisor  = b_q;
    assign out_data     = data_q;
    assign out_rd       = rd_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a cycle-counting divider stand-in, a transaction
// timeline model of the expected outputs, and directed vectors.
module tb_div_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = '0;
    logic [63:0] in_src2 = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        div_valid, div_flush, div_word;
    logic [1:0]  div_signed;
    logic [63:0] div_dividend, div_divisor;
    logic        div_ready;
    logic        div_out_valid;
    logic [63:0] div_quotient, div_remainder;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl #(.XLEN(64), .RD_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .flush(flush),
        .div_valid(div_valid), .div_flush(div_flush), .div_word(div_word),
        .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_out_valid(div_out_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ext(input logic [63:0] s, input logic w, input logic sgn);
        if (!w) return s;
        return sgn ? {{32{s[31]}}, s[31:0]} : {32'b0, s[31:0]};
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        if (w) return (b[31:0] == 32'd0) ||
                      (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // RISC-V M-extension result of the instruction as architecturally defined
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0)                                             r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == '1)     r32 = op[1] ? 32'd0 : a32;
            else if (!op[0])  r32 = op[1] ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else              r32 = op[1] ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0)                                                   r = op[1] ? a : '1;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)   r = op[1] ? 64'd0 : a;
        else if (!op[0])      r = op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else                  r = op[1] ? a % b : a / b;
        return r;
    endfunction

    // Raw divider output: W results zero-extended from 32 bits
    function automatic logic [63:0] div_raw(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input logic sgn, input logic rem);
        logic [31:0] a32, b32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (sgn) r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else     r32 = rem ? a32 % b32 : a32 / b32;
            return {32'b0, r32};
        end
        if (sgn) return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return rem ? a % b : a / b;
    endfunction

    // ---------------- divider stand-in ----------------
    logic dbusy;
    int   dcnt;
    logic [63:0] dq, dr;
    assign div_ready     = !dbusy;
    assign div_quotient  = dq;
    assign div_remainder = dr;

    // 64 (or 32) cycles after launch, one result pulse
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dbusy <= 1'b0; dcnt <= 0; div_out_valid <= 1'b0; dq <= '0; dr <= '0;
        end else begin
            div_out_valid <= 1'b0;
            if (div_flush) begin
                dbusy <= 1'b0;
            end else if (dbusy) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    dbusy         <= 1'b0;
                    div_out_valid <= 1'b1;
                end
            end else if (div_valid) begin
                dbusy <= 1'b1;
                dcnt  <= div_word ? 32 : 64;
                dq    <= div_raw(div_dividend, div_divisor, div_word, div_signed[0], 1'b0);
                dr    <= div_raw(div_dividend, div_divisor, div_word, div_signed[0], 1'b1);
            end
        end
    end

    // ---------------- transaction timeline model ----------------
    int          cyc = 0;
    logic        m_busy, m_have, m_special, m_word;
    logic [1:0]  m_op;
    int          m_t, m_out_cyc;
    logic [63:0] m_a, m_b, m_data;
    logic [4:0]  m_rd;

    // Tracks one in-flight instruction: when its launch and result are due
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_have <= 1'b0; m_special <= 1'b0; m_word <= 1'b0;
            m_op <= '0; m_t <= 0; m_out_cyc <= 0; m_a <= '0; m_b <= '0; m_data <= '0; m_rd <= '0;
        end else begin
            if (m_busy) begin
                if (flush || (cyc >= m_out_cyc && out_ready)) m_busy <= 1'b0;
            end else if (in_valid && !flush) begin
                m_busy    <= 1'b1;
                m_have    <= 1'b1;
                m_op      <= in_op;
                m_word    <= in_word;
                m_rd      <= in_rd;
                m_a       <= ext(in_src1, in_word, !in_op[0]);
                m_b       <= ext(in_src2, in_word, !in_op[0]);
                m_special <= is_special(in_op, in_word, in_src1, in_src2);
                m_data    <= ref_result(in_op, in_word, in_src1, in_src2);
                m_t       <= cyc + 1;
                m_out_cyc <= cyc + 1 + (is_special(in_op, in_word, in_src1, in_src2) ? 0 :
                                        (in_word ? 34 : 66));
            end
            cyc <= cyc + 1;
        end
    end

    // Every cycle out of reset, the DUT must match the model
    always @(negedge clock) begin
        if (reset) begin
            chk("in_ready",     in_ready,  !m_busy);
            chk("out_valid",    out_valid, m_busy && cyc >= m_out_cyc);
            chk("div_valid",    div_valid, m_busy && !m_special && cyc == m_t && !flush);
            chk("div_flush",    div_flush, m_busy && !m_special && cyc > m_t && cyc < m_out_cyc && flush);
            chk("div_dividend", div_dividend, m_a);
            chk("div_divisor",  div_divisor,  m_b);
            if (m_have) begin
                chk("div_word",   div_word,   m_word);
                chk("div_signed", div_signed, m_op[0] ? 2'b00 : 2'b11);
            end
            if (m_busy && cyc >= m_out_cyc) begin
                chk("out_data", out_data, m_data);
                chk("out_rd",   out_rd,   m_rd);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic launch(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, output int t0);
        @(posedge clock); #1;
        in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_rd = rd;
        @(posedge clock); #1;
        in_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp, input int lat, input int hold);
        int  t0;
        bit  found;
        found = 0;
        out_ready = (hold == 0);
        launch(op, w, a, b, rd, t0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            chk({name, " timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, " latency"}, 64'(cyc - t0 + 1), 64'(lat));
            chk({name, " data"},    out_data, exp);
            chk({name, " rd"},      64'(out_rd), 64'(rd));
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            #1 out_ready = 1'b1;
        end
        @(posedge clock); #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " out_valid"},    out_valid,    1'b0);
        chk({name, " in_ready"},     in_ready,     1'b1);
        chk({name, " div_valid"},    div_valid,    1'b0);
        chk({name, " div_flush"},    div_flush,    1'b0);
        chk({name, " out_data"},     out_data,     64'd0);
        chk({name, " out_rd"},       64'(out_rd),  64'd0);
        chk({name, " div_dividend"}, div_dividend, 64'd0);
        chk({name, " div_divisor"},  div_divisor,  64'd0);
    endtask

    initial begin
        int t0;
        #2 chk_reset_outputs("reset");
        @(negedge clock); @(negedge clock);
        reset = 1'b1;

        do_op("divu",   2'b01, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14, 67, 0);
        do_op("remu",   2'b11, 1'b0, 64'd100, 64'd7, 5'd4, 64'd2,  67, 0);
        do_op("div",    2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5,
              64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
        do_op("rem",    2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
              64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
        do_op("divu0",  2'b01, 1'b0, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        do_op("remw0",  2'b10, 1'b1, 64'h1_8000_0005, 64'd0, 5'd8,
              64'hFFFF_FFFF_8000_0005, 1, 0);
        do_op("divovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
              64'h8000_0000_0000_0000, 1, 0);
        do_op("divwovf", 2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10,
              64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("remwovf", 2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd11, 64'd0, 1, 0);
        do_op("divuw",  2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd12,
              64'hFFFF_FFFF_FFFF_FFFF, 35, 5);

        // Flush while the divider is busy, then a fresh operation
        launch(2'b01, 1'b0, 64'd100, 64'd7, 5'd13, t0);
        while (cyc != t0 + 19) begin @(posedge clock); #1; end
        flush = 1'b1;
        @(negedge clock);
        chk("flush div_flush", div_flush, 1'b1);
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        chk("flush idle", in_ready, 1'b1);
        repeat (3) @(posedge clock);
        do_op("divu after flush", 2'b01, 1'b0, 64'd9, 64'd3, 5'd14, 64'd3, 67, 0);

        // Flush beats out_ready in DONE: the result is dropped
        out_ready = 1'b0;
        launch(2'b01, 1'b0, 64'd5, 64'd0, 5'd15, t0);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        chk("done flush valid", out_valid, 1'b1);
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        chk("done flush dropped", out_valid, 1'b0);

        // Asynchronous reset in the middle of a division
        launch(2'b01, 1'b0, 64'd100, 64'd7, 5'd16, t0);
        while (cyc != t0 + 9) begin @(posedge clock); #1; end
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midreset");
        #3 reset = 1'b1;
        do_op("div after reset", 2'b00, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd17,
              64'hFFFF_FFFF_FFFF_FFFA, 67, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
